// File: rtl/radio_spi_master.sv
// SPI mode-0 command serializer for the MAX2829 radio and AD9777 DAC chip selects.
// One command word per transfer, sent starting at cmd_data[0].
module radio_spi_master #(
   parameter int CLK_DIV  = 4,
   parameter int MAX_BITS = 24
) (
   input  logic                controller_logic_clk,
   input  logic                controller_reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_target,
   input  logic [4:0]          cmd_len,
   input  logic [0:MAX_BITS-1] cmd_data,
   output logic                cmd_done,
   output logic                controller_spi_clk,
   output logic                controller_spi_data,
   output logic                controller_radio_cs,
   output logic                controller_dac_cs
);

   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
   localparam logic [5:0] MAX_LEN  = 6'(MAX_BITS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_GAP_A,
      ST_GAP_B
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [4:0]          bit_q, bit_d;
   logic [0:MAX_BITS-1] shift_q, shift_d;
   logic                target_q, target_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;
   logic                sclk_q, sclk_d;
   logic                sdata_q, sdata_d;
   logic                radio_cs_q, radio_cs_d;
   logic                dac_cs_q, dac_cs_d;

   logic [5:0]          len_eff;
   logic [4:0]          len_m1;
   logic                cnt_zero;
   logic                active_d;

   assign len_eff  = (cmd_len == 5'd0 || {1'b0, cmd_len} > MAX_LEN) ? MAX_LEN : {1'b0, cmd_len};
   assign len_m1   = 5'(len_eff - 6'd1);
   assign cnt_zero = (cnt_q == 8'd0);

   // The gap is split into two D-cycle halves so the counter never needs more than 8 bits.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      target_d = target_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && ready_q) begin
               state_d  = ST_SETUP;
               cnt_d    = DIV_LOAD;
               bit_d    = len_m1;
               shift_d  = cmd_data;
               target_d = cmd_target;
            end
         end
         ST_SETUP: begin
            cnt_d = cnt_zero ? DIV_LOAD : cnt_q - 8'd1;
            if (cnt_zero) state_d = ST_HIGH;
         end
         ST_HIGH: begin
            cnt_d = cnt_zero ? DIV_LOAD : cnt_q - 8'd1;
            if (cnt_zero) begin
               state_d = ST_LOW;
               if (bit_q != 5'd0) shift_d = {shift_q[1:MAX_BITS-1], 1'b0};
            end
         end
         ST_LOW: begin
            cnt_d = cnt_zero ? DIV_LOAD : cnt_q - 8'd1;
            if (cnt_zero) begin
               if (bit_q == 5'd0) begin
                  state_d = ST_GAP_A;
               end else begin
                  state_d = ST_HIGH;
                  bit_d   = bit_q - 5'd1;
               end
            end
         end
         ST_GAP_A: begin
            cnt_d = cnt_zero ? DIV_LOAD : cnt_q - 8'd1;
            if (cnt_zero) state_d = ST_GAP_B;
         end
         ST_GAP_B: begin
            cnt_d = cnt_zero ? DIV_LOAD : cnt_q - 8'd1;
            if (cnt_zero) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every pin comes straight from a flop.
   always_comb begin
      active_d   = (state_d == ST_SETUP) || (state_d == ST_HIGH) || (state_d == ST_LOW);
      ready_d    = (state_d == ST_IDLE);
      sclk_d     = (state_d == ST_HIGH);
      sdata_d    = active_d ? shift_d[0] : 1'b0;
      radio_cs_d = !(active_d && !target_d);
      dac_cs_d   = !(active_d && target_d);
   end

   always_ff @(posedge controller_logic_clk) begin
      if (controller_reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 8'd0;
         bit_q      <= 5'd0;
         shift_q    <= '0;
         target_q   <= 1'b0;
         ready_q    <= 1'b0;
         done_q     <= 1'b0;
         sclk_q     <= 1'b0;
         sdata_q    <= 1'b0;
         radio_cs_q <= 1'b1;
         dac_cs_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         target_q   <= target_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         sclk_q     <= sclk_d;
         sdata_q    <= sdata_d;
         radio_cs_q <= radio_cs_d;
         dac_cs_q   <= dac_cs_d;
      end
   end

   assign cmd_ready           = ready_q;
   assign cmd_done            = done_q;
   assign controller_spi_clk  = sclk_q;
   assign controller_spi_data = sdata_q;
   assign controller_radio_cs = radio_cs_q;
   assign controller_dac_cs   = dac_cs_q;

endmodule

// File: tb/tb_radio_spi_master.sv
// Randomized bench for radio_spi_master: a CLK_DIV=4 and a CLK_DIV=1 instance checked
// against a transfer-level model (expected bit list, edge count and done cycle).
module tb_radio_spi_master;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        v4, t4, r4, dn4, sc4, sd4, rc4, dc4;
   logic [4:0]  l4;
   logic [0:23] d4;
   logic        v1, t1, r1, dn1, sc1, sd1, rc1, dc1;
   logic [4:0]  l1;
   logic [0:23] d1;

   radio_spi_master #(.CLK_DIV(4), .MAX_BITS(24)) dut4 (
      .controller_logic_clk(clk), .controller_reset(rst),
      .cmd_valid(v4), .cmd_ready(r4), .cmd_target(t4), .cmd_len(l4), .cmd_data(d4),
      .cmd_done(dn4), .controller_spi_clk(sc4), .controller_spi_data(sd4),
      .controller_radio_cs(rc4), .controller_dac_cs(dc4));

   radio_spi_master #(.CLK_DIV(1), .MAX_BITS(24)) dut1 (
      .controller_logic_clk(clk), .controller_reset(rst),
      .cmd_valid(v1), .cmd_ready(r1), .cmd_target(t1), .cmd_len(l1), .cmd_data(d1),
      .cmd_done(dn1), .controller_spi_clk(sc1), .controller_spi_data(sd1),
      .controller_radio_cs(rc1), .controller_dac_cs(dc1));

   int checks = 0;
   int errors = 0;
   int sel    = 4;

   logic m_ready, m_done, m_sclk, m_sdata, m_rcs, m_dcs;
   always_comb begin
      m_ready = (sel == 1) ? r1  : r4;
      m_done  = (sel == 1) ? dn1 : dn4;
      m_sclk  = (sel == 1) ? sc1 : sc4;
      m_sdata = (sel == 1) ? sd1 : sd4;
      m_rcs   = (sel == 1) ? rc1 : rc4;
      m_dcs   = (sel == 1) ? dc1 : dc4;
   end

   task automatic drive(input int which, input logic v, input logic t,
                        input logic [4:0] l, input logic [0:23] d);
      if (which == 1) begin
         v1 = v; t1 = t; l1 = l; d1 = d;
      end else begin
         v4 = v; t4 = t; l4 = l; d4 = d;
      end
   endtask

   task automatic set_valid(input int which, input logic v);
      if (which == 1) v1 = v;
      else v4 = v;
   endtask

   // Starts one command at the current negedge (which must see ready=1) and follows it to done.
   task automatic run_xfer(input int which, input int div, input logic tgt,
                           input logic [4:0] len, input logic [0:23] data, input bit hold);
      int          L, exp_done, done_cyc, edges, tail_hi, hi_run, lo_run;
      logic [0:23] exp_bits, got_bits;
      bit          other_low, timing_bad, data_moved, done_seen, ready_bad, idle_data;
      logic        prev_sclk, hi_data, tcs, ocs;
      logic [4:0]  gl;
      logic [0:23] gd;
      sel = which;
      L = (int'(len) == 0 || int'(len) > 24) ? 24 : int'(len);
      exp_bits = '0;
      for (int k = 0; k < L; k++) exp_bits[k] = data[k];
      exp_done = 3 * div + 2 * L * div + 1;
      got_bits = '0;
      edges = 0; tail_hi = 0; hi_run = 0; lo_run = 0; done_cyc = 0;
      other_low = 0; timing_bad = 0; data_moved = 0; done_seen = 0; ready_bad = 0; idle_data = 0;
      prev_sclk = 1'b0; hi_data = 1'b0;
      checks++;
      if (m_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL accept_ready: got %b expected 1", m_ready);
      end
      drive(which, 1'b1, tgt, len, data);
      for (int cyc = 1; cyc <= exp_done + 40 && !done_seen; cyc++) begin
         @(negedge clk);
         if (cyc == 1 && !hold) set_valid(which, 1'b0);
         if (cyc == 2) begin
            gl = 5'($urandom);
            gd = 24'($urandom);
            drive(which, hold, ~tgt, gl, gd);
         end
         tcs = tgt ? m_dcs : m_rcs;
         ocs = tgt ? m_rcs : m_dcs;
         if (cyc == 1) begin
            checks++;
            if (tcs !== 1'b0) begin
               errors++;
               $display("[TB] FAIL cs_fall: got %b expected 0 on cycle 1", tcs);
            end
         end
         if (ocs !== 1'b1) other_low = 1;
         if (m_ready !== 1'b0 && m_done !== 1'b1) ready_bad = 1;
         if (tcs === 1'b1 && ocs === 1'b1 && m_sdata !== 1'b0) idle_data = 1;
         if (edges == L && tcs === 1'b1) tail_hi++;
         if (m_sclk === 1'b1 && prev_sclk === 1'b0) begin
            if (edges < 24) got_bits[edges] = m_sdata;
            edges++;
            if (lo_run != div) timing_bad = 1;
            hi_data = m_sdata;
            hi_run = 0;
         end
         if (m_sclk === 1'b0 && prev_sclk === 1'b1) begin
            if (hi_run != div) timing_bad = 1;
            lo_run = 0;
         end
         if (m_sclk === 1'b1) begin
            hi_run++;
            if (m_sdata !== hi_data) data_moved = 1;
         end
         if (m_sclk === 1'b0 && tcs === 1'b0) lo_run++;
         if (m_done === 1'b1) begin
            done_seen = 1;
            done_cyc = cyc;
         end
         prev_sclk = m_sclk;
      end
      checks++;
      if (!done_seen || done_cyc != exp_done) begin
         errors++;
         $display("[TB] FAIL done_cycle: got %0d (seen=%0d) expected %0d", done_cyc, done_seen, exp_done);
      end
      checks++;
      if (edges != L) begin
         errors++;
         $display("[TB] FAIL edge_count: got %0d expected %0d", edges, L);
      end
      checks++;
      if (got_bits !== exp_bits) begin
         errors++;
         $display("[TB] FAIL bits: got %h expected %h", got_bits, exp_bits);
      end
      checks++;
      if (other_low) begin
         errors++;
         $display("[TB] FAIL other_cs: got low expected steady 1");
      end
      checks++;
      if (tail_hi != 2 * div + 1) begin
         errors++;
         $display("[TB] FAIL cs_high_tail: got %0d expected %0d", tail_hi, 2 * div + 1);
      end
      checks++;
      if (timing_bad || data_moved) begin
         errors++;
         $display("[TB] FAIL sclk_timing: got bad=%0d moved=%0d expected 0 0", timing_bad, data_moved);
      end
      checks++;
      if (ready_bad || idle_data) begin
         errors++;
         $display("[TB] FAIL busy_outputs: got ready_bad=%0d idle_data=%0d expected 0 0", ready_bad, idle_data);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({rc4, dc4, sc4, sd4, dn4, r4} !== 6'b110000 || {rc1, dc1, sc1, sd1, dn1, r1} !== 6'b110000) begin
            errors++;
            $display("[TB] FAIL reset_values: got %b %b expected 110000 110000",
                     {rc4, dc4, sc4, sd4, dn4, r4}, {rc1, dc1, sc1, sd1, dn1, r1});
         end
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (r4 !== 1'b1 || r1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ready_after_reset: got %b%b expected 11", r4, r1);
      end
   endtask

   task automatic test_radio;
      logic [0:23] d;
      d = {18'h2A5C3, 6'($urandom)};
      run_xfer(4, 4, 1'b0, 5'd18, d, 0);
      idle_cycles(3);
   endtask

   task automatic test_dac;
      logic [0:23] d;
      d = {16'h8A5F, 8'($urandom)};
      run_xfer(4, 4, 1'b1, 5'd16, d, 0);
      idle_cycles(2);
   endtask

   task automatic test_back_to_back;
      logic [0:23] d;
      logic [4:0]  l;
      d = 24'($urandom);
      l = 5'($urandom_range(1, 24));
      run_xfer(4, 4, 1'($urandom), l, d, 1);
      d = 24'($urandom);
      l = 5'($urandom_range(1, 24));
      run_xfer(4, 4, 1'($urandom), l, d, 0);
      idle_cycles(2);
   endtask

   task automatic test_random;
      logic [0:23] d;
      logic [4:0]  l;
      for (int n = 0; n < 6; n++) begin
         d = 24'($urandom);
         l = 5'($urandom);
         run_xfer(4, 4, 1'($urandom), l, d, 0);
         idle_cycles(int'($urandom_range(0, 3)));
      end
      for (int n = 0; n < 4; n++) begin
         d = 24'($urandom);
         l = 5'($urandom);
         run_xfer(1, 1, 1'($urandom), l, d, 0);
         idle_cycles(int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_reset_mid;
      int   edges;
      bit   hit, done_bad;
      logic prev;
      sel = 4;
      edges = 0; hit = 0; done_bad = 0; prev = 1'b0;
      drive(4, 1'b1, 1'b0, 5'd18, 24'($urandom));
      for (int cyc = 1; cyc < 400 && !hit; cyc++) begin
         @(negedge clk);
         if (cyc == 1) set_valid(4, 1'b0);
         if (m_sclk === 1'b1 && prev === 1'b0) edges++;
         if (m_done === 1'b1) done_bad = 1;
         if (edges == 6 && m_sclk === 1'b1) hit = 1;
         prev = m_sclk;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("[TB] FAIL reach_bit5: got edges=%0d expected 6 within bound", edges);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({rc4, dc4, sc4, sd4, dn4} !== 5'b11000) begin
         errors++;
         $display("[TB] FAIL mid_reset: got %b expected 11000", {rc4, dc4, sc4, sd4, dn4});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (r4 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_reset_ready: got %b expected 1", r4);
      end
      repeat (20) begin
         @(negedge clk);
         if (dn4 !== 1'b0 || rc4 !== 1'b1) done_bad = 1;
      end
      checks++;
      if (done_bad) begin
         errors++;
         $display("[TB] FAIL mid_reset_no_done: got done/cs activity expected none");
      end
   endtask

   task automatic test_len0_div1;
      run_xfer(1, 1, 1'($urandom), 5'd0, 24'($urandom), 0);
      idle_cycles(2);
      run_xfer(1, 1, 1'($urandom), 5'd30, 24'($urandom), 0);
      idle_cycles(2);
   endtask

   initial begin
      rst = 1'b1;
      drive(4, 1'b0, 1'b0, 5'd0, '0);
      drive(1, 1'b0, 1'b0, 5'd0, '0);
      test_reset;
      test_radio;
      test_dac;
      test_back_to_back;
      test_random;
      test_reset_mid;
      test_len0_div1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
